// File: rtl/bcd_seven_seg_scan.sv
// Time-multiplexes a latched ones/tens/hundreds BCD score onto a 4-digit common-anode display.
// Optional leading-zero blanking of tens/hundreds is enabled with `define LEADING_ZERO_BLANK_EN.
module bcd_seven_seg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [1:0] hundreds,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       digit_sel_q, digit_sel_d;
  logic [3:0]       snap_ones_q, snap_ones_d;
  logic [3:0]       snap_tens_q, snap_tens_d;
  logic [1:0]       snap_hund_q, snap_hund_d;
  logic             primed_q, primed_d;
  logic             frame_tick_q, frame_tick_d;

  logic [3:0] digit_val;
  logic       digit_blank;

  // Snapshot happens on the priming edge and on every frame wrap (digit 2 -> 0).
  always_comb begin
    div_cnt_d    = div_cnt_q;
    digit_sel_d  = digit_sel_q;
    snap_ones_d  = snap_ones_q;
    snap_tens_d  = snap_tens_q;
    snap_hund_d  = snap_hund_q;
    primed_d     = primed_q;
    frame_tick_d = 1'b0;
    if (!primed_q) begin
      primed_d     = 1'b1;
      snap_ones_d  = ones;
      snap_tens_d  = tens;
      snap_hund_d  = hundreds;
      frame_tick_d = 1'b1;
    end else if (div_cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      div_cnt_d = '0;
      if (digit_sel_q == 2'd2) begin
        digit_sel_d  = 2'd0;
        snap_ones_d  = ones;
        snap_tens_d  = tens;
        snap_hund_d  = hundreds;
        frame_tick_d = 1'b1;
      end else begin
        digit_sel_d = digit_sel_q + 2'd1;
      end
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      digit_sel_q  <= 2'd0;
      snap_ones_q  <= 4'd0;
      snap_tens_q  <= 4'd0;
      snap_hund_q  <= 2'd0;
      primed_q     <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      digit_sel_q  <= digit_sel_d;
      snap_ones_q  <= snap_ones_d;
      snap_tens_q  <= snap_tens_d;
      snap_hund_q  <= snap_hund_d;
      primed_q     <= primed_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  always_comb begin
    digit_val   = snap_ones_q;
    digit_blank = 1'b0;
    case (digit_sel_q)
      2'd1: begin
        digit_val = snap_tens_q;
`ifdef LEADING_ZERO_BLANK_EN
        digit_blank = (snap_hund_q == 2'd0) && (snap_tens_q == 4'd0);
`endif
      end
      2'd2: begin
        digit_val = {2'b00, snap_hund_q};
`ifdef LEADING_ZERO_BLANK_EN
        digit_blank = (snap_hund_q == 2'd0);
`endif
      end
      default: digit_val = snap_ones_q;
    endcase
  end

  always_comb begin
    an  = 4'b1111;
    seg = 7'h7F;
    if (primed_q) begin
      case (digit_sel_q)
        2'd0:    an = 4'b1110;
        2'd1:    an = 4'b1101;
        2'd2:    an = 4'b1011;
        default: an = 4'b1111;
      endcase
      if (!digit_blank) begin
        case (digit_val)
          4'd0:    seg = 7'h40;
          4'd1:    seg = 7'h79;
          4'd2:    seg = 7'h24;
          4'd3:    seg = 7'h30;
          4'd4:    seg = 7'h19;
          4'd5:    seg = 7'h12;
          4'd6:    seg = 7'h02;
          4'd7:    seg = 7'h78;
          4'd8:    seg = 7'h00;
          4'd9:    seg = 7'h10;
          default: seg = 7'h3F;
        endcase
      end
    end
  end

  assign dp         = 1'b1;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bcd_seven_seg_scan.sv
// Bench for bcd_seven_seg_scan with REFRESH_DIV=4; reference model counts cycles since priming.
module tb_bcd_seven_seg_scan;

  localparam int RD    = 4;
  localparam int FRAME = 3 * RD;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ones, tens;
  logic [1:0] hundreds;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  bit       m_primed;
  int       m_t;
  int       m_so, m_st, m_sh;
  bit       m_tick;
  int       tick_cnt;
  logic [6:0] seg_tab [10];

  bcd_seven_seg_scan #(.REFRESH_DIV(RD), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .ones(ones), .tens(tens), .hundreds(hundreds),
    .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int cur_digit();
    return (m_t / RD) % 3;
  endfunction

  function automatic logic [6:0] exp_seg();
    int d, v;
    if (!m_primed) return 7'h7F;
    d = cur_digit();
    v = (d == 0) ? m_so : (d == 1) ? m_st : m_sh;
`ifdef LEADING_ZERO_BLANK_EN
    if (d == 2 && m_sh == 0) return 7'h7F;
    if (d == 1 && m_sh == 0 && m_st == 0) return 7'h7F;
`endif
    if (v > 9) return 7'h3F;
    return seg_tab[v];
  endfunction

  function automatic logic [3:0] exp_an();
    if (!m_primed) return 4'b1111;
    return ~(4'b0001 << cur_digit());
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_primed = 0; m_t = 0; m_tick = 0;
      m_so = 0; m_st = 0; m_sh = 0;
    end else if (!m_primed) begin
      m_primed = 1; m_t = 0; m_tick = 1;
      m_so = ones; m_st = tens; m_sh = hundreds;
    end else begin
      m_t++;
      m_tick = (m_t % FRAME == 0);
      if (m_tick) begin
        m_so = ones; m_st = tens; m_sh = hundreds;
      end
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("an", {3'b000, an}, {3'b000, exp_an()});
    check("seg", seg, exp_seg());
    check("dp", {6'd0, dp}, 7'd1);
    check("frame_tick", {6'd0, frame_tick}, {6'd0, m_tick});
    if (frame_tick) tick_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_digit(input int d);
    for (int i = 0; i < FRAME && !(m_primed && cur_digit() == d); i++) cyc();
    check("wait_digit", {5'd0, m_primed && cur_digit() == d}, 7'd1);
  endtask

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
    m_primed = 0; m_t = 0; m_tick = 0; m_so = 0; m_st = 0; m_sh = 0; tick_cnt = 0;

    // Reset and prime with ones=5
    rst = 1; ones = 4'd5; tens = 4'd0; hundreds = 2'd0;
    run(3);
    check("reset_an", {3'b000, an}, 7'h0F);
    check("reset_seg", seg, 7'h7F);
    rst = 0;
    cyc();
    check("prime_tick", {6'd0, frame_tick}, 7'd1);
    check("prime_an", {3'b000, an}, 7'h0E);
    check("prime_seg", seg, 7'h12);
    run(3);
    check("digit0_hold_seg", seg, 7'h12);

    // Full scan of 255
    ones = 4'd5; tens = 4'd5; hundreds = 2'd2;
    run(2 * FRAME);
    wait_digit(2);
    check("hund_255", seg, 7'h24);

    // Mid-frame change while tens is lit
    wait_digit(1);
    ones = 4'd0; tens = 4'd0; hundreds = 2'd0;
    check("tens_old", seg, 7'h12);
    tick_cnt = 0;
    run(3 * FRAME);
    check("tick_per_frame", 7'(tick_cnt), 7'd3);

    // Invalid BCD on ones
    ones = 4'hC;
    run(FRAME);
    wait_digit(0);
    check("invalid_seg", seg, 7'h3F);

    // Leading-zero cases: 7 and 15
    ones = 4'd7; tens = 4'd0; hundreds = 2'd0;
    run(2 * FRAME);
    ones = 4'd5; tens = 4'd1; hundreds = 2'd0;
    run(2 * FRAME);

    // Reset while hundreds is lit, then restart
    wait_digit(2);
    rst = 1;
    cyc();
    check("midreset_an", {3'b000, an}, 7'h0F);
    check("midreset_seg", seg, 7'h7F);
    rst = 0;
    cyc();
    check("reprime_tick", {6'd0, frame_tick}, 7'd1);
    check("reprime_an", {3'b000, an}, 7'h0E);

    // Randomized inputs changing at random points
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        ones = 4'($urandom_range(0, 15));
        tens = 4'($urandom_range(0, 15));
        hundreds = 2'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 0;
    run(FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
